divider_seq: RTL and testbench



---
 rtl/divider_pkg.sv | 12 +
 rtl/divider_step.sv | 25 ++
 rtl/divider_seq.sv | 152 +++++++++++++++
 tb/tb_divider_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared types and helpers for the sequential radix-2 restoring divider.
package divider_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} div_state_t;

    localparam int DIV_WIDTH_DEFAULT = 32;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/divider_step.sv
// One combinational restoring-division iteration: shift in a bit, trial-subtract.
module divider_step
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem < divisor on entry, so a borrow means the shifted value fits WIDTH bits
    always_comb begin
        shifted = {rem_i, bit_i};
        trial   = shifted - {1'b0, divisor_i};
        q_o     = ~trial[WIDTH];
        rem_o   = q_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/divider_seq.sv
// Iterative unsigned divider, one quotient bit per clock, start/busy/done handshake.
// Optional result self-check enabled by defining DIVIDER_CHECK_EN.
module divider_seq
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
`ifdef DIVIDER_CHECK_EN
    output logic             check_err,
`endif
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    div_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

`ifdef DIVIDER_CHECK_EN
    logic [WIDTH-1:0] orig_q, orig_d;
    logic             chk_q, chk_d;
    logic [WIDTH-1:0] chk_sum;
`endif

    // quo_q doubles as the dividend shift register: MSB out, quotient bit in
    divider_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .bit_i     (quo_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        dbz_d   = dbz_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef DIVIDER_CHECK_EN
        orig_d  = orig_q;
        chk_d   = chk_q;
        chk_sum = '0;
`endif
        unique case (state_q)
            IDLE, FINISH: begin
                state_d = IDLE;
                if (start) begin
`ifdef DIVIDER_CHECK_EN
                    orig_d = dividend;
                    chk_d  = 1'b0;
`endif
                    if (divisor != '0) begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                        cnt_d   = CW'(WIDTH);
                        quo_d   = dividend;
                        rem_d   = '0;
                        dvs_d   = divisor;
                        dbz_d   = 1'b0;
                    end else begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                        quo_d   = '1;
                        rem_d   = dividend;
                        dvs_d   = '0;
                        dbz_d   = 1'b1;
                    end
                end
            end
            RUN: begin
                rem_d  = step_rem;
                quo_d  = {quo_q[WIDTH-2:0], step_q};
                cnt_d  = cnt_q - CW'(1);
                busy_d = 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = FINISH;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`ifdef DIVIDER_CHECK_EN
                    chk_sum = quo_d * dvs_q + rem_d;
                    chk_d   = (chk_sum != orig_q) || (rem_d >= dvs_q);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
`ifdef DIVIDER_CHECK_EN
            orig_q  <= '0;
            chk_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
`ifdef DIVIDER_CHECK_EN
            orig_q  <= orig_d;
            chk_q   <= chk_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

`ifdef DIVIDER_CHECK_EN
    assign check_err = chk_q;

    a_no_check_err: assert property (@(posedge clk) disable iff (!rst_n) !chk_q);
`endif

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: directed table, corner sequences, random vs. model.
module tb_divider_seq;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
`ifdef DIVIDER_CHECK_EN
    logic         check_err;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    divider_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
`ifdef DIVIDER_CHECK_EN
        .check_err   (check_err),
`endif
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Called at a negedge; accepted at the following posedge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    // Cycle 1 = first negedge after the accepting edge. Returns at the done negedge.
    task automatic wait_done(input int inj, output int lat, output logic busy_err);
        lat = -1;
        busy_err = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = k;
                if (busy) busy_err = 1'b1;
                break;
            end
            if (!busy) busy_err = 1'b1;
            if (k == inj) begin
                start    = 1'b1;
                dividend = 32'd9;
                divisor  = 32'd3;
            end
        end
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] a,
                                input logic [W-1:0] b, input int lat, input logic berr);
        logic [W-1:0] eq, er;
        int           elat;
        if (b == '0) begin
            eq = '1; er = a; elat = 1;
        end else begin
            eq = a / b; er = a % b; elat = W + 1;
        end
        chk({tag, " latency"}, 64'(lat), 64'(elat));
        chk({tag, " busy"}, 64'(berr), 64'(0));
        chk({tag, " quotient"}, 64'(quotient), 64'(eq));
        chk({tag, " remainder"}, 64'(remainder), 64'(er));
        chk({tag, " dbz"}, 64'(div_by_zero), 64'(b == '0));
`ifdef DIVIDER_CHECK_EN
        chk({tag, " check_err"}, 64'(check_err), 64'(0));
`endif
    endtask

    vec_t tbl[8];
    int   lat;
    logic berr;
    logic saw_done;

    initial begin
        tbl[0] = '{32'd100,        32'd7,         32'd14,         32'd2,  1'b0};
        tbl[1] = '{32'd120,        32'd5,         32'd24,         32'd0,  1'b0};
        tbl[2] = '{32'd3,          32'd10,        32'd0,          32'd3,  1'b0};
        tbl[3] = '{32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF,  32'd0,  1'b0};
        tbl[4] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,          32'd0,  1'b0};
        tbl[5] = '{32'd5,          32'd0,         32'hFFFF_FFFF,  32'd5,  1'b1};
        tbl[6] = '{32'd5,          32'd0,         32'hFFFF_FFFF,  32'd5,  1'b1};
        tbl[7] = '{32'h8000_0000,  32'd3,         32'd715827882,  32'd2,  1'b0};

        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset done", 64'(done), 64'(0));
        chk("reset quotient", 64'(quotient), 64'(0));
        chk("reset remainder", 64'(remainder), 64'(0));
        chk("reset dbz", 64'(div_by_zero), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Table entries are issued back-to-back, each launched in the previous done cycle
        for (int i = 0; i < 8; i++) begin
            launch(tbl[i].a, tbl[i].b);
            wait_done(0, lat, berr);
            chk($sformatf("tbl%0d latency", i), 64'(lat), tbl[i].z ? 64'(1) : 64'(W + 1));
            chk($sformatf("tbl%0d busy", i), 64'(berr), 64'(0));
            chk($sformatf("tbl%0d quotient", i), 64'(quotient), 64'(tbl[i].q));
            chk($sformatf("tbl%0d remainder", i), 64'(remainder), 64'(tbl[i].r));
            chk($sformatf("tbl%0d dbz", i), 64'(div_by_zero), 64'(tbl[i].z));
        end
        @(negedge clk);
        chk("done single pulse", 64'(done), 64'(0));
        chk("idle busy", 64'(busy), 64'(0));
        chk("held quotient", 64'(quotient), 64'(715827882));

        // Start pulse with new operands mid-run must be ignored
        launch(32'd1000, 32'd3);
        wait_done(10, lat, berr);
        check_result("ignore", 32'd1000, 32'd3, lat, berr);
        @(negedge clk);
        chk("ignore no restart", 64'(busy), 64'(0));

        // Reset in the middle of a divide aborts it
        launch(32'd1000, 32'd3);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort busy", 64'(busy), 64'(0));
        chk("abort done", 64'(done), 64'(0));
        chk("abort quotient", 64'(quotient), 64'(0));
        chk("abort remainder", 64'(remainder), 64'(0));
        chk("abort dbz", 64'(div_by_zero), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        chk("abort no done", 64'(saw_done), 64'(0));
        launch(32'd8, 32'd2);
        wait_done(0, lat, berr);
        check_result("after abort", 32'd8, 32'd2, lat, berr);

        // Random operands against plain / and %
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] a, b;
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = $urandom & 32'h0000_FFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            launch(a, b);
            wait_done(0, lat, berr);
            check_result($sformatf("rand%0d", i), a, b, lat, berr);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
